// File: rtl/ps2_kbd_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : ps2_kbd_ctrl_if
// Description : Byte-level link between ps2_kbd_ctrl and the ps2_keyboard core.
//               master : controller side (drives command/send)
//               slave  : keyboard core side (drives status and receive data)
//   ps2_command                       byte to transmit
//   ps2_command_send                  transmit request, held until done/fail
//   ps2_command_was_sent              core pulse: byte transmitted
//   ps2_error_communication_timed_out core pulse: transmit failed
//   ps2_data                          received byte
//   ps2_data_clk                      one-cycle strobe, ps2_data valid
// Revision    : 1.0 - initial release
// ============================================================================
interface ps2_kbd_ctrl_if;
    logic [7:0] ps2_command;
    logic       ps2_command_send;
    logic       ps2_command_was_sent;
    logic       ps2_error_communication_timed_out;
    logic [7:0] ps2_data;
    logic       ps2_data_clk;

    modport master (
        output ps2_command,
        output ps2_command_send,
        input  ps2_command_was_sent,
        input  ps2_error_communication_timed_out,
        input  ps2_data,
        input  ps2_data_clk
    );

    modport slave (
        input  ps2_command,
        input  ps2_command_send,
        output ps2_command_was_sent,
        output ps2_error_communication_timed_out,
        output ps2_data,
        output ps2_data_clk
    );
endinterface
`default_nettype wire

// File: rtl/ps2_kbd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ps2_kbd_ctrl
// Description : Sequences the ps2_keyboard core: reset/BAT init, Set-LEDs
//               command pair with retries, scan-code decoding (E0/F0) and a
//               first-word-fall-through event FIFO for the host.
// Ports       : CLOCK_50, RESET_N (async, active-low)
//               ps2          - ps2_kbd_ctrl_if.master link to the core
//               led_req/led_value/led_busy - LED command request
//               kbd_data/kbd_empty/kbd_rd   - event FIFO head {rel, ext, code}
//               kbd_overflow/kbd_ovf_clr    - sticky dropped-event flag
//               init_done, kbd_err          - init passed / retries exhausted
// Options     : PS2_KBD_CTRL_TYPEMATIC_FILTER_EN - drop auto-repeat makes
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_kbd_ctrl #(
    parameter int FIFO_DEPTH   = 16,
    parameter int RESP_TIMEOUT = 25_000_000,
    parameter int MAX_RETRY    = 3
) (
    input  wire logic       CLOCK_50,
    input  wire logic       RESET_N,
    ps2_kbd_ctrl_if.master  ps2,
    input  wire logic       led_req,
    input  wire logic [2:0] led_value,
    output logic            led_busy,
    output logic [9:0]      kbd_data,
    output logic            kbd_empty,
    input  wire logic       kbd_rd,
    output logic            kbd_overflow,
    input  wire logic       kbd_ovf_clr,
    output logic            init_done,
    output logic            kbd_err
);
    localparam int c_aw  = (FIFO_DEPTH < 2) ? 1 : $clog2(FIFO_DEPTH);
    localparam int c_rw  = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam int c_tw  = $clog2(RESP_TIMEOUT + 1);
    localparam logic [c_rw-1:0] c_retry_max = c_rw'(MAX_RETRY);
    localparam logic [c_tw-1:0] c_tmo_last  = c_tw'(RESP_TIMEOUT - 1);

    typedef enum logic [2:0] {
        RST_SEND, RST_ACK, RST_BAT, IDLE,
        LED_SEND0, LED_ACK0, LED_SEND1, LED_ACK1
    } state_t;

    state_t          r_state;
    logic [7:0]      r_cmd;
    logic            r_send;
    logic            r_busy;
    logic            r_init_done;
    logic            r_err;
    logic [2:0]      r_led_val;
    logic [c_rw-1:0] r_retry;
    logic [c_tw-1:0] r_tmo;

    logic            w_is_send, w_is_wait, w_ok, w_fail;
    logic [7:0]      w_expect, w_tx_byte;
    state_t          w_resend_state, w_wait_state;

    // ------------------------------------------------------------------
    // Command engine decode
    // ------------------------------------------------------------------
    always_comb begin
        w_is_send = (r_state == RST_SEND) || (r_state == LED_SEND0) || (r_state == LED_SEND1);
        w_is_wait = (r_state == RST_ACK) || (r_state == RST_BAT) ||
                    (r_state == LED_ACK0) || (r_state == LED_ACK1);
        w_expect  = (r_state == RST_BAT) ? 8'hAA : 8'hFA;
        w_ok      = w_is_wait && ps2.ps2_data_clk && (ps2.ps2_data == w_expect);
        // Any reply other than the expected one (0xFE, 0xFC, junk), a reply
        // timeout, or a core transmit failure is a retry of the current byte.
        w_fail    = (w_is_send && r_send && !ps2.ps2_command_was_sent &&
                     ps2.ps2_error_communication_timed_out) ||
                    (w_is_wait && ps2.ps2_data_clk && (ps2.ps2_data != w_expect)) ||
                    (w_is_wait && !ps2.ps2_data_clk && (r_tmo == c_tmo_last));

        w_resend_state = RST_SEND;
        w_wait_state   = RST_ACK;
        w_tx_byte      = r_cmd;
        case (r_state)
            RST_SEND:  begin w_tx_byte = 8'hFF;                 w_wait_state = RST_ACK;  end
            LED_SEND0: begin w_tx_byte = 8'hED;                 w_wait_state = LED_ACK0; end
            LED_SEND1: begin w_tx_byte = {5'b0, r_led_val};     w_wait_state = LED_ACK1; end
            default:   ;
        endcase
        case (r_state)
            LED_SEND0, LED_ACK0: w_resend_state = LED_SEND0;
            LED_SEND1, LED_ACK1: w_resend_state = LED_SEND1;
            default:             w_resend_state = RST_SEND;
        endcase
    end

    // ------------------------------------------------------------------
    // Command FSM. A SEND state is entered with send low (except from IDLE,
    // where the first byte goes out immediately), so every retry drops the
    // request for at least one cycle before re-raising it.
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state     <= RST_SEND;
            r_cmd       <= 8'h00;
            r_send      <= 1'b0;
            r_busy      <= 1'b1;
            r_init_done <= 1'b0;
            r_err       <= 1'b0;
            r_led_val   <= 3'b000;
            r_retry     <= '0;
            r_tmo       <= '0;
        end else begin
            if (w_is_wait)
                r_tmo <= r_tmo + 1'b1;
            if (w_fail) begin
                r_send <= 1'b0;
                if (r_retry == c_retry_max) begin
                    r_retry <= '0;
                    r_err   <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end else begin
                    r_retry <= r_retry + 1'b1;
                    r_state <= w_resend_state;
                end
            end else begin
                case (r_state)
                    RST_SEND, LED_SEND0, LED_SEND1: begin
                        if (!r_send) begin
                            r_send <= 1'b1;
                            r_cmd  <= w_tx_byte;
                        end else if (ps2.ps2_command_was_sent) begin
                            r_send  <= 1'b0;
                            r_tmo   <= '0;
                            r_state <= w_wait_state;
                        end
                    end
                    RST_ACK: if (w_ok) begin
                        r_tmo   <= '0;
                        r_state <= RST_BAT;
                    end
                    RST_BAT: if (w_ok) begin
                        r_init_done <= 1'b1;
                        r_busy      <= 1'b0;
                        r_retry     <= '0;
                        r_state     <= IDLE;
                    end
                    IDLE: if (led_req) begin
                        r_led_val <= led_value;
                        r_cmd     <= 8'hED;
                        r_send    <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= LED_SEND0;
                    end
                    LED_ACK0: if (w_ok) begin
                        r_retry <= '0;
                        r_state <= LED_SEND1;
                    end
                    LED_ACK1: if (w_ok) begin
                        r_retry <= '0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Scan-code decoder: only IDLE bytes that are not controller replies.
    // ------------------------------------------------------------------
    logic       w_route;
    logic       r_ext, r_rel, r_push;
    logic [9:0] r_push_data;

    assign w_route = (r_state == IDLE) && ps2.ps2_data_clk &&
                     !(ps2.ps2_data inside {8'hFA, 8'hAA, 8'hFE, 8'hEE, 8'h00, 8'hFF});

`ifdef PS2_KBD_CTRL_TYPEMATIC_FILTER_EN
    logic       r_filt_vld;
    logic [8:0] r_filt_key;
    logic       w_filt_hit;
    assign w_filt_hit = r_filt_vld && (r_filt_key == {r_ext, ps2.ps2_data});
`endif

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_ext       <= 1'b0;
            r_rel       <= 1'b0;
            r_push      <= 1'b0;
            r_push_data <= 10'h000;
`ifdef PS2_KBD_CTRL_TYPEMATIC_FILTER_EN
            r_filt_vld  <= 1'b0;
            r_filt_key  <= 9'h000;
`endif
        end else begin
            r_push <= 1'b0;
            if (w_is_send) begin
                r_ext <= 1'b0;
                r_rel <= 1'b0;
            end else if (w_route) begin
                if (ps2.ps2_data == 8'hE0) begin
                    r_ext <= 1'b1;
                end else if (ps2.ps2_data == 8'hF0) begin
                    r_rel <= 1'b1;
                end else begin
                    r_push_data <= {r_rel, r_ext, ps2.ps2_data};
                    r_ext       <= 1'b0;
                    r_rel       <= 1'b0;
`ifdef PS2_KBD_CTRL_TYPEMATIC_FILTER_EN
                    // A repeated make of the held key is auto-repeat; its
                    // release re-arms the filter.
                    if (!r_rel) begin
                        r_push     <= !w_filt_hit;
                        r_filt_vld <= 1'b1;
                        r_filt_key <= {r_ext, ps2.ps2_data};
                    end else begin
                        r_push <= 1'b1;
                        if (w_filt_hit)
                            r_filt_vld <= 1'b0;
                    end
`else
                    r_push <= 1'b1;
`endif
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO (first-word-fall-through). Pointers carry one extra bit so
    // full and empty are distinguishable.
    // ------------------------------------------------------------------
    logic [9:0]    r_mem [FIFO_DEPTH];
    logic [c_aw:0] r_wp, r_rp;
    logic          r_ovf;
    logic          w_empty, w_full, w_pop, w_wr;

    assign w_empty = (r_wp == r_rp);
    assign w_full  = (r_wp[c_aw] != r_rp[c_aw]) && (r_wp[c_aw-1:0] == r_rp[c_aw-1:0]);
    assign w_pop   = kbd_rd && !w_empty;
    assign w_wr    = r_push && (!w_full || w_pop);

    always_ff @(posedge CLOCK_50) begin
        if (w_wr)
            r_mem[r_wp[c_aw-1:0]] <= r_push_data;
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (w_wr)
                r_wp <= r_wp + 1'b1;
            if (w_pop)
                r_rp <= r_rp + 1'b1;
            if (r_push && w_full && !w_pop)
                r_ovf <= 1'b1;
            else if (kbd_ovf_clr)
                r_ovf <= 1'b0;
        end
    end

    assign ps2.ps2_command      = r_cmd;
    assign ps2.ps2_command_send = r_send;
    assign led_busy             = r_busy;
    assign kbd_empty            = w_empty;
    assign kbd_data             = w_empty ? 10'h000 : r_mem[r_rp[c_aw-1:0]];
    assign kbd_overflow         = r_ovf;
    assign init_done            = r_init_done;
    assign kbd_err              = r_err;
endmodule
`default_nettype wire

// File: tb/tb_ps2_kbd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_kbd_ctrl
// Description : Self-checking bench for ps2_kbd_ctrl. A small keyboard-core
//               model acknowledges every transmit request and logs the byte;
//               the main sequence plays keyboard replies and scan codes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_kbd_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       led_req, kbd_rd, kbd_ovf_clr;
    logic [2:0] led_value;
    logic       led_busy, kbd_empty, kbd_overflow, init_done, kbd_err;
    logic [9:0] kbd_data;

    int errors = 0;
    int checks = 0;
    logic [7:0] sent_q[$];

    ps2_kbd_ctrl_if ifc();

    ps2_kbd_ctrl #(.FIFO_DEPTH(16), .RESP_TIMEOUT(60), .MAX_RETRY(3)) dut (
        .CLOCK_50(clk), .RESET_N(rst_n), .ps2(ifc.master),
        .led_req(led_req), .led_value(led_value), .led_busy(led_busy),
        .kbd_data(kbd_data), .kbd_empty(kbd_empty), .kbd_rd(kbd_rd),
        .kbd_overflow(kbd_overflow), .kbd_ovf_clr(kbd_ovf_clr),
        .init_done(init_done), .kbd_err(kbd_err)
    );

    always #5 clk = ~clk;

    // Keyboard core model: accept a held send request after two cycles.
    initial begin
        ifc.ps2_command_was_sent = 1'b0;
        ifc.ps2_error_communication_timed_out = 1'b0;
        forever begin
            @(negedge clk);
            if (ifc.ps2_command_send && !ifc.ps2_command_was_sent) begin
                repeat (2) @(negedge clk);
                sent_q.push_back(ifc.ps2_command);
                ifc.ps2_command_was_sent = 1'b1;
                @(negedge clk);
                ifc.ps2_command_was_sent = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        ifc.ps2_data = b;
        ifc.ps2_data_clk = 1'b1;
        @(negedge clk);
        ifc.ps2_data_clk = 1'b0;
    endtask

    task automatic pop();
        @(negedge clk);
        kbd_rd = 1'b1;
        @(negedge clk);
        kbd_rd = 1'b0;
    endtask

    task automatic pulse_led(input logic [2:0] v);
        @(negedge clk);
        led_value = v;
        led_req   = 1'b1;
        @(negedge clk);
        led_req   = 1'b0;
    endtask

    task automatic expect_tx(input string name, input logic [7:0] exp);
        int n = 0;
        while (sent_q.size() == 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (sent_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got no transmission required 0x%0h", name, exp);
        end else begin
            chk(name, {8'h00, sent_q.pop_front()}, {8'h00, exp});
        end
    endtask

    typedef struct {
        logic [7:0] b;
        logic       push;
        logic [9:0] data;
    } dec_vec_t;

    dec_vec_t   vecs[17];
    logic [9:0] exp_f[$];

    initial begin
        vecs[0]  = '{8'h1C, 1'b1, 10'h01C};
        vecs[1]  = '{8'hF0, 1'b0, 10'h000};
        vecs[2]  = '{8'h1C, 1'b1, 10'h21C};
        vecs[3]  = '{8'hE0, 1'b0, 10'h000};
        vecs[4]  = '{8'h75, 1'b1, 10'h175};
        vecs[5]  = '{8'hE0, 1'b0, 10'h000};
        vecs[6]  = '{8'hF0, 1'b0, 10'h000};
        vecs[7]  = '{8'h75, 1'b1, 10'h375};
        vecs[8]  = '{8'hFA, 1'b0, 10'h000};
        vecs[9]  = '{8'hAA, 1'b0, 10'h000};
        vecs[10] = '{8'hFE, 1'b0, 10'h000};
        vecs[11] = '{8'hEE, 1'b0, 10'h000};
        vecs[12] = '{8'h00, 1'b0, 10'h000};
        vecs[13] = '{8'hFF, 1'b0, 10'h000};
        vecs[14] = '{8'hE0, 1'b0, 10'h000};
        vecs[15] = '{8'hFA, 1'b0, 10'h000};  // discarded: ext flag survives
        vecs[16] = '{8'h6B, 1'b1, 10'h16B};

        rst_n = 1'b0; led_req = 1'b0; led_value = 3'b000;
        kbd_rd = 1'b0; kbd_ovf_clr = 1'b0;
        ifc.ps2_data = 8'h00; ifc.ps2_data_clk = 1'b0;

        // ---------------- reset values ----------------
        repeat (3) @(negedge clk);
        chk("rst_cmd",   {8'h00, ifc.ps2_command}, 16'h0000);
        chk("rst_send",  {15'h0, ifc.ps2_command_send}, 16'h0);
        chk("rst_busy",  {15'h0, led_busy}, 16'h1);
        chk("rst_data",  {6'h0, kbd_data}, 16'h0);
        chk("rst_empty", {15'h0, kbd_empty}, 16'h1);
        chk("rst_ovf",   {15'h0, kbd_overflow}, 16'h0);
        chk("rst_init",  {15'h0, init_done}, 16'h0);
        chk("rst_err",   {15'h0, kbd_err}, 16'h0);

        // ---------------- init ----------------
        rst_n = 1'b1;
        @(negedge clk);
        chk("init_send_rise", {15'h0, ifc.ps2_command_send}, 16'h1);
        chk("init_cmd",       {8'h00, ifc.ps2_command}, 16'h00FF);
        expect_tx("init_tx_ff", 8'hFF);
        send_byte(8'hFA);
        chk("init_not_yet", {15'h0, init_done}, 16'h0);
        send_byte(8'hAA);
        chk("init_done", {15'h0, init_done}, 16'h1);
        chk("init_busy", {15'h0, led_busy}, 16'h0);
        chk("init_err",  {15'h0, kbd_err}, 16'h0);
        repeat (5) @(negedge clk);
        chk("init_no_extra_tx", sent_q.size(), 16'h0);

        // ---------------- decode table ----------------
        foreach (vecs[i]) begin
            send_byte(vecs[i].b);
            chk($sformatf("dec%0d_latency", i), {15'h0, kbd_empty}, 16'h1);
            @(negedge clk);
            if (vecs[i].push) begin
                chk($sformatf("dec%0d_empty", i), {15'h0, kbd_empty}, 16'h0);
                chk($sformatf("dec%0d_data", i), {6'h0, kbd_data}, {6'h0, vecs[i].data});
                pop();
                chk($sformatf("dec%0d_popped", i), {15'h0, kbd_empty}, 16'h1);
            end else begin
                chk($sformatf("dec%0d_nopush", i), {15'h0, kbd_empty}, 16'h1);
            end
        end

        // ---------------- LED command ----------------
        pulse_led(3'b101);
        chk("led_busy_n1", {15'h0, led_busy}, 16'h1);
        chk("led_send_n1", {15'h0, ifc.ps2_command_send}, 16'h1);
        chk("led_cmd_n1",  {8'h00, ifc.ps2_command}, 16'h00ED);
        expect_tx("led_tx_ed", 8'hED);
        pulse_led(3'b010);                // ignored while busy
        send_byte(8'hFA);
        expect_tx("led_tx_val", 8'h05);
        chk("led_busy_pre", {15'h0, led_busy}, 16'h1);
        send_byte(8'hFA);
        chk("led_busy_fall", {15'h0, led_busy}, 16'h0);
        chk("led_no_event", {15'h0, kbd_empty}, 16'h1);

        // ---------------- retry exhaustion ----------------
        pulse_led(3'b001);
        for (int i = 0; i < 4; i++) begin
            expect_tx($sformatf("retry_tx%0d", i), 8'hED);
            chk($sformatf("retry_err_pre%0d", i), {15'h0, kbd_err}, 16'h0);
            send_byte(8'hFE);
        end
        chk("retry_err",  {15'h0, kbd_err}, 16'h1);
        chk("retry_idle", {15'h0, led_busy}, 16'h0);
        repeat (20) @(negedge clk);
        chk("retry_no_5th", sent_q.size(), 16'h0);
        chk("retry_send_low", {15'h0, ifc.ps2_command_send}, 16'h0);

        // ---------------- reply timeout ----------------
        pulse_led(3'b110);
        expect_tx("tmo_tx0", 8'hED);
        expect_tx("tmo_tx1", 8'hED);      // no reply: same byte again
        send_byte(8'hFA);
        expect_tx("tmo_val", 8'h06);
        send_byte(8'hFA);
        chk("tmo_busy", {15'h0, led_busy}, 16'h0);
        chk("tmo_err_sticky", {15'h0, kbd_err}, 16'h1);

        // ---------------- FIFO limits ----------------
        for (int i = 0; i < 17; i++) send_byte(8'h10 + 8'(i));
        repeat (3) @(negedge clk);
        chk("fifo_ovf",  {15'h0, kbd_overflow}, 16'h1);
        chk("fifo_head", {6'h0, kbd_data}, 16'h010);
        @(negedge clk); kbd_ovf_clr = 1'b1;
        @(negedge clk); kbd_ovf_clr = 1'b0;
        chk("fifo_ovf_clr", {15'h0, kbd_overflow}, 16'h0);
        @(negedge clk); ifc.ps2_data = 8'h21; ifc.ps2_data_clk = 1'b1;
        @(negedge clk); ifc.ps2_data_clk = 1'b0; kbd_rd = 1'b1;
        @(negedge clk); kbd_rd = 1'b0;
        repeat (2) @(negedge clk);
        chk("fifo_pushpop_no_ovf", {15'h0, kbd_overflow}, 16'h0);
        for (int i = 0; i < 15; i++) begin
            chk($sformatf("fifo_drain%0d", i), {6'h0, kbd_data}, 16'h011 + 16'(i));
            pop();
        end
        chk("fifo_last", {6'h0, kbd_data}, 16'h021);
        pop();
        chk("fifo_empty", {15'h0, kbd_empty}, 16'h1);

        // ---------------- typematic ----------------
`ifdef PS2_KBD_CTRL_TYPEMATIC_FILTER_EN
        exp_f = '{10'h01C, 10'h21C};
`else
        exp_f = '{10'h01C, 10'h01C, 10'h01C, 10'h21C};
`endif
        send_byte(8'h1C); send_byte(8'h1C); send_byte(8'h1C);
        send_byte(8'hF0); send_byte(8'h1C);
        repeat (3) @(negedge clk);
        begin
            int n = 0;
            while (!kbd_empty && n < 8) begin
                if (n < exp_f.size())
                    chk($sformatf("filt_data%0d", n), {6'h0, kbd_data}, {6'h0, exp_f[n]});
                pop();
                n++;
            end
            chk("filt_count", 16'(n), 16'(exp_f.size()));
        end

        // ---------------- reset mid-operation ----------------
        send_byte(8'h33);
        @(negedge clk);
        chk("mid_event", {15'h0, kbd_empty}, 16'h0);
        pulse_led(3'b111);
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk);
        chk("mid_empty", {15'h0, kbd_empty}, 16'h1);
        chk("mid_init",  {15'h0, init_done}, 16'h0);
        chk("mid_busy",  {15'h0, led_busy}, 16'h1);
        chk("mid_send",  {15'h0, ifc.ps2_command_send}, 16'h0);
        repeat (6) @(negedge clk);
        sent_q.delete();
        rst_n = 1'b1;
        expect_tx("mid_tx_ff", 8'hFF);
        send_byte(8'hFA);
        send_byte(8'hAA);
        chk("mid_reinit", {15'h0, init_done}, 16'h1);
        chk("mid_err_cleared", {15'h0, kbd_err}, 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
